regfile_storage: RTL and testbench

Storage stage of the 64-bit, 32-entry register file. It sits directly upstream of the 32-to-1 read muxes and drives the packed [31:0][63:0] register bus that both read ports select from. It holds one write port with a valid/ready handshake, a hardwired-zero register X31, per-register written flags, and a sequenced bulk-clear engine.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_storage_decoder5_32.sv | 12 +
 rtl/regfile_storage.sv | 102 ++++++++++
 tb/tb_regfile_storage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 64-bit, 32-entry register file.
// The read-mux stage imports reg_bus_t from here as well.
package regfile_pkg;

   localparam int REGS     = 32;
   localparam int WIDTH    = 64;
   localparam int ADDRBITS = 5;
   localparam int ZERO_REG = 31;

   localparam logic [REGS-1:0] ZERO_MASK = {{(REGS-1){1'b0}}, 1'b1} << ZERO_REG;
   localparam logic [ADDRBITS-1:0] LAST_CLR = ADDRBITS'(REGS - 2);

   typedef logic [REGS-1:0][WIDTH-1:0] reg_bus_t;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

endpackage

// File: rtl/regfile_storage_decoder5_32.sv
// Enable plus 5-bit index to a 32-bit one-hot select vector.
module decoder5_32
   import regfile_pkg::*;
(
   input  logic                en,
   input  logic [ADDRBITS-1:0] addr,
   output logic [REGS-1:0]     onehot
);

   assign onehot = {{(REGS-1){1'b0}}, en} << addr;

endmodule

// File: rtl/regfile_storage.sv
// Storage stage of the register file: one handshaked write port, a hardwired
// zero register, per-register written flags and a sequenced bulk-clear sweep.
module regfile_storage
   import regfile_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [ADDRBITS-1:0]        wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       clr_req,
   output logic                       clr_busy,
   output logic                       clr_done,
   output logic [REGS-1:0][WIDTH-1:0] regs,
   output logic [REGS-1:0]            wr_mask
);

   clr_state_t          state;
   logic [ADDRBITS-1:0] counter;
   logic [REGS-1:0]     wr_sel;
   logic [REGS-1:0]     clr_sel;
   logic [REGS-1:0]     wr_keep;
   reg_bus_t            store;

   decoder5_32 u_wr_dec (
      .en     (wr_valid & wr_ready),
      .addr   (wr_addr),
      .onehot (wr_sel)
   );

   decoder5_32 u_clr_dec (
      .en     (state == CLEAR),
      .addr   (counter),
      .onehot (clr_sel)
   );

   // Writes to the zero register complete the handshake but are dropped here.
   assign wr_keep = wr_sel & ~ZERO_MASK;
   assign regs    = store;

   // NOTE: the storage array takes the async reset too, because reset must
   // leave every register reading zero, not just the control state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store <= '0;
      end else begin
         for (int n = 0; n < REGS; n++) begin
            if (clr_sel[n])
               store[n] <= '0;
            else if (wr_keep[n])
               store[n] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         counter  <= '0;
         wr_mask  <= '0;
         wr_ready <= 1'b1;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr_mask <= wr_mask | wr_keep;
               if (clr_req) begin
                  // A write landing on this edge keeps its data but not its flag.
                  state    <= CLEAR;
                  counter  <= '0;
                  wr_mask  <= '0;
                  wr_ready <= 1'b0;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               counter <= counter + 1'b1;
               if (counter == LAST_CLR) begin
                  state    <= DONE;
                  wr_ready <= 1'b1;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end
            end
            DONE: begin
               wr_mask  <= wr_mask | wr_keep;
               state    <= IDLE;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b1;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_storage.sv
// Directed bench for regfile_storage: table-driven writes plus hand-written
// clear, write-during-clear, same-edge and reset-abort sequences.
module tb_regfile_storage;
   import regfile_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       wr_valid = 1'b0;
   logic                       wr_ready;
   logic [ADDRBITS-1:0]        wr_addr = '0;
   logic [WIDTH-1:0]           wr_data = '0;
   logic                       clr_req = 1'b0;
   logic                       clr_busy;
   logic                       clr_done;
   logic [REGS-1:0][WIDTH-1:0] regs;
   logic [REGS-1:0]            wr_mask;

   int checks = 0;
   int errors = 0;

   regfile_storage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .regs     (regs),
      .wr_mask  (wr_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                v;
      logic [ADDRBITS-1:0] a;
      logic [WIDTH-1:0]    d;
      logic [WIDTH-1:0]    exp_val;
      logic [REGS-1:0]     exp_mask;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Single write issued on a falling edge, accepted on the next rising edge.
   task automatic do_write(input logic [ADDRBITS-1:0] a, input logic [WIDTH-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic start_clear();
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
   endtask

   // Wait (bounded) at falling edges until clr_done is seen.
   task automatic wait_done(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (clr_done) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   initial begin
      int   nz;
      int   busy_cnt;
      int   bad;
      logic seen;

      vecs[0] = '{1'b1, 5'd3,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 32'h0000_0008};
      vecs[1] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  32'h0000_0008};
      vecs[2] = '{1'b0, 5'd4,  64'h1234,                64'h0,                  32'h0000_0008};
      vecs[3] = '{1'b1, 5'd0,  64'hA5,                  64'hA5,                 32'h0000_0009};
      vecs[4] = '{1'b1, 5'd3,  64'h55,                  64'h55,                 32'h0000_0009};
      vecs[5] = '{1'b1, 5'd30, 64'h1E,                  64'h1E,                 32'h4000_0009};

      // Reset state
      #12;
      nz = 0;
      for (int n = 0; n < REGS; n++) if (regs[n] != '0) nz++;
      check("rst_regs_nonzero", 64'(nz), 64'd0);
      check("rst_mask", 64'(wr_mask), 64'd0);
      check("rst_ready", 64'(wr_ready), 64'd1);
      check("rst_busy", 64'(clr_busy), 64'd0);
      check("rst_done", 64'(clr_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven writes
      for (int i = 0; i < 6; i++) begin
         wr_valid = vecs[i].v;
         wr_addr  = vecs[i].a;
         wr_data  = vecs[i].d;
         #1;
         check($sformatf("vec%0d_ready", i), 64'(wr_ready), 64'd1);
         if (i == 0) check("vec0_no_bypass", regs[3], 64'd0);
         @(negedge clk);
         wr_valid = 1'b0;
         check($sformatf("vec%0d_val", i), regs[vecs[i].a], vecs[i].exp_val);
         check($sformatf("vec%0d_mask", i), 64'(wr_mask), 64'(vecs[i].exp_mask));
         if (i == 0) begin
            nz = 0;
            for (int n = 0; n < REGS; n++) if (n != 3 && regs[n] != '0) nz++;
            check("vec0_others_zero", 64'(nz), 64'd0);
         end
      end

      // Fill 0..30 with n+1, then sweep
      for (int n = 0; n < REGS - 1; n++) do_write(ADDRBITS'(n), 64'(n + 1));
      check("fill_mask", 64'(wr_mask), 64'h7FFF_FFFF);
      start_clear();
      check("clr_mask_cleared", 64'(wr_mask), 64'd0);
      for (int k = 0; k < REGS - 1; k++) begin
         check($sformatf("clr%0d_busy", k), 64'(clr_busy), 64'd1);
         check($sformatf("clr%0d_ready", k), 64'(wr_ready), 64'd0);
         check($sformatf("clr%0d_done", k), 64'(clr_done), 64'd0);
         check($sformatf("clr%0d_pre", k), regs[k], 64'(k + 1));
         if (k > 0) check($sformatf("clr%0d_prev_zero", k), regs[k-1], 64'd0);
         @(negedge clk);
      end
      check("clr_done_pulse", 64'(clr_done), 64'd1);
      check("clr_done_busy", 64'(clr_busy), 64'd0);
      check("clr_done_ready", 64'(wr_ready), 64'd1);
      check("clr_last_zero", regs[30], 64'd0);
      @(negedge clk);
      check("clr_done_drop", 64'(clr_done), 64'd0);
      nz = 0;
      for (int n = 0; n < REGS; n++) if (regs[n] != '0) nz++;
      check("clr_all_zero", 64'(nz), 64'd0);
      check("clr_final_mask", 64'(wr_mask), 64'd0);

      // Write held during CLEAR is only accepted in DONE
      start_clear();
      wr_valid = 1'b1;
      wr_addr  = 5'd5;
      wr_data  = 64'h5555;
      busy_cnt = 0;
      bad = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (clr_done) seen = 1'b1;
         else begin
            if (clr_busy) busy_cnt++;
            if (wr_ready || wr_mask != '0 || regs[5] != '0) bad++;
            @(negedge clk);
         end
      end
      check("held_done_seen", 64'(seen), 64'd1);
      check("held_busy_cycles", 64'(busy_cnt), 64'd31);
      check("held_no_accept", 64'(bad), 64'd0);
      check("held_ready_in_done", 64'(wr_ready), 64'd1);
      check("held_reg5_in_done", regs[5], 64'd0);
      @(negedge clk);
      wr_valid = 1'b0;
      check("held_reg5_after", regs[5], 64'h5555);
      check("held_mask_after", 64'(wr_mask), 64'h20);

      // clr_req and a write to 7 on the same edge
      clr_req  = 1'b1;
      wr_valid = 1'b1;
      wr_addr  = 5'd7;
      wr_data  = 64'h77;
      @(negedge clk);
      clr_req  = 1'b0;
      wr_valid = 1'b0;
      check("same_reg7_written", regs[7], 64'h77);
      check("same_mask_zero", 64'(wr_mask), 64'd0);
      check("same_busy", 64'(clr_busy), 64'd1);
      repeat (7) @(negedge clk);
      check("same_reg7_before_step", regs[7], 64'h77);
      @(negedge clk);
      check("same_reg7_swept", regs[7], 64'd0);
      wait_done(seen);
      check("same_done_seen", 64'(seen), 64'd1);
      @(negedge clk);
      check("same_mask_after", 64'(wr_mask), 64'd0);
      check("same_reg5_swept", regs[5], 64'd0);

      // Reset at sweep step 10 aborts the clear
      do_write(5'd20, 64'hABC);
      start_clear();
      repeat (10) @(negedge clk);
      check("abort_busy_pre", 64'(clr_busy), 64'd1);
      check("abort_reg20_pre", regs[20], 64'hABC);
      #2 rst_n = 1'b0;
      #1;
      check("abort_reg20", regs[20], 64'd0);
      check("abort_busy", 64'(clr_busy), 64'd0);
      check("abort_ready", 64'(wr_ready), 64'd1);
      check("abort_done", 64'(clr_done), 64'd0);
      check("abort_mask", 64'(wr_mask), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (clr_done || clr_busy) bad++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(bad), 64'd0);
      do_write(5'd2, 64'h22);
      check("abort_idle_write", regs[2], 64'h22);
      check("abort_idle_mask", 64'(wr_mask), 64'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
